// File: rtl/dsp48_pkg.sv
// Shared definitions for the DSP48A1 MAC sequencer.
// Contents:
//   - OPMODE encodings issued to the slice.
//   - Bit positions of the OPMODE fields.
//   - Sequencer state type.
//   - A helper that builds a clean OPMODE word.
package dsp48_pkg;

  // OPMODE field positions
  localparam int OPM_X_LO    = 0;
  localparam int OPM_X_HI    = 1;
  localparam int OPM_Z_LO    = 2;
  localparam int OPM_Z_HI    = 3;
  localparam int OPM_PREADD  = 4;
  localparam int OPM_CIN     = 5;
  localparam int OPM_PRESUB  = 6;
  localparam int OPM_POSTSUB = 7;

  // X=M, Z=0 : start a new accumulation
  localparam logic [7:0] OPM_FIRST = 8'h01;
  // X=M, Z=P : accumulate
  localparam logic [7:0] OPM_ACC   = 8'h09;
  // X=0, Z=P : hold P unchanged
  localparam logic [7:0] OPM_HOLD  = 8'h08;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // Keeps only the X/Z mux selects of a base encoding and applies the pre-adder
  // flag. Carry-in, pre-subtract and post-subtract are forced off.
  function automatic logic [7:0] opm_build(input logic [7:0] base, input logic preadd);
    logic [7:0] v;
    v                        = 8'h00;
    v[OPM_X_HI:OPM_X_LO]     = base[OPM_X_HI:OPM_X_LO];
    v[OPM_Z_HI:OPM_Z_LO]     = base[OPM_Z_HI:OPM_Z_LO];
    v[OPM_PREADD]            = preadd;
    v[OPM_CIN]               = 1'b0;
    v[OPM_PRESUB]            = 1'b0;
    v[OPM_POSTSUB]           = 1'b0;
    return v;
  endfunction

endpackage

// File: rtl/dsp_lat_shift.sv
// Latency-matching shift registers for the MAC sequencer.
// Purpose:
//   - Delays the issued OPMODE by OPM_SKEW cycles, so it meets its operands at
//     the slice post-adder.
//   - Delays a one-bit "last tap" token by TOK_DEPTH cycles to time the
//     capture of DSP_P.
// Ports:
//   i_clk, i_rst_n  clock, async active-low reset
//   i_opm / o_opm   OPMODE in / delayed out (pass-through when OPM_SKEW=0)
//   i_last / o_last last-tap token in / delayed out
module dsp_lat_shift #(
  parameter int OPM_SKEW  = 1,
  parameter int TOK_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [7:0] i_opm,
  input  logic       i_last,
  output logic [7:0] o_opm,
  output logic       o_last
);

  logic [TOK_DEPTH-1:0] r_tok;

  // last-tap token delay line
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_tok <= {TOK_DEPTH{1'b0}};
    end else begin
      r_tok <= TOK_DEPTH'({r_tok, i_last});
    end
  end

  assign o_last = r_tok[TOK_DEPTH-1];

  if (OPM_SKEW == 0) begin : g_no_skew
    assign o_opm = i_opm;
  end else begin : g_skew
    logic [7:0] r_opm_pipe [OPM_SKEW];

    // OPMODE delay line
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int i = 0; i < OPM_SKEW; i++) r_opm_pipe[i] <= 8'h00;
      end else begin
        r_opm_pipe[0] <= i_opm;
        for (int i = 1; i < OPM_SKEW; i++) r_opm_pipe[i] <= r_opm_pipe[i-1];
      end
    end

    assign o_opm = r_opm_pipe[OPM_SKEW-1];
  end

endmodule

// File: rtl/dsp_mac_sequencer.sv
// Upstream control stage for a DSP48A1 slice. It runs an N-tap
// multiply-accumulate frame and captures the slice P output as the result.
// Optional feature macro: SYMMETRIC_PREADD_EN.
//   - Defined: DSP_D follows IN_D and the pre-adder is enabled.
//   - Undefined: DSP_D=0 and the result is sum(A*B).
// Ports:
//   CLK, RST_N                  clock, async active-low reset
//   CFG_TAPS                    taps per frame, latched on first accept (0 -> 1)
//   IN_VALID/IN_READY           operand-pair handshake
//   IN_A/IN_B/IN_D              sample, coefficient, mirror sample
//   DSP_A/DSP_B/DSP_D           operands to the slice
//   DSP_OPMODE, DSP_CE          slice control
//   DSP_P                       slice P output
//   RES/RES_VALID/RES_READY     result handshake
//   BUSY                        state is not IDLE
module dsp_mac_sequencer
  import dsp48_pkg::*;
#(
  parameter int PIPE_LAT = 3,
  parameter int OPM_SKEW = 1,
  parameter int MAX_TAPS = 255
) (
  input  logic                          CLK,
  input  logic                          RST_N,
  input  logic [$clog2(MAX_TAPS+1)-1:0] CFG_TAPS,
  input  logic                          IN_VALID,
  output logic                          IN_READY,
  input  logic [17:0]                   IN_A,
  input  logic [17:0]                   IN_B,
  input  logic [17:0]                   IN_D,
  output logic [17:0]                   DSP_A,
  output logic [17:0]                   DSP_B,
  output logic [17:0]                   DSP_D,
  output logic [7:0]                    DSP_OPMODE,
  output logic                          DSP_CE,
  input  logic [47:0]                   DSP_P,
  output logic [47:0]                   RES,
  output logic                          RES_VALID,
  input  logic                          RES_READY,
  output logic                          BUSY
);

  localparam int TW = $clog2(MAX_TAPS + 1);
  localparam logic [TW-1:0] ONE_TAP = TW'(1);
`ifdef SYMMETRIC_PREADD_EN
  localparam logic PREADD_ON = 1'b1;
`else
  localparam logic PREADD_ON = 1'b0;
`endif

  state_t      r_state, w_state_nxt;
  logic [TW-1:0] r_taps, r_cnt, w_taps_nxt, w_cnt_nxt, w_cfg_eff;
  logic        r_in_ready, r_busy, r_ce;
  logic [17:0] r_dsp_a, r_dsp_b, r_dsp_d, w_a_iss, w_b_iss, w_d_iss;
  logic [7:0]  r_opm_iss, w_opm_iss, w_opm_dly;
  logic        r_last_iss, w_last_iss, w_preadd;
  logic        w_tok_out, r_p_rdy, w_p_done, w_cap, w_accept;
  logic [47:0] r_res;
  logic        r_res_valid;

  assign w_accept  = IN_VALID & r_in_ready;
  assign w_cfg_eff = (CFG_TAPS == {TW{1'b0}}) ? ONE_TAP : CFG_TAPS;
  // P is final once the token arrives; r_p_rdy remembers that while the
  // result slot is still occupied.
  assign w_p_done  = w_tok_out | r_p_rdy;
  assign w_cap     = (r_state == DRAIN) & w_p_done & (~r_res_valid | RES_READY);

  // next-state and operand-issue decode
  always_comb begin
    w_state_nxt = r_state;
    w_taps_nxt  = r_taps;
    w_cnt_nxt   = r_cnt;
    w_a_iss     = 18'd0;
    w_b_iss     = 18'd0;
    w_d_iss     = 18'd0;
    w_opm_iss   = OPM_HOLD;
    w_preadd    = 1'b0;
    w_last_iss  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_taps_nxt = w_cfg_eff;
          w_cnt_nxt  = ONE_TAP;
          w_a_iss    = IN_A;
          w_b_iss    = IN_B;
          w_d_iss    = IN_D & {18{PREADD_ON}};
          w_opm_iss  = OPM_FIRST;
          w_preadd   = PREADD_ON;
          if (w_cfg_eff == ONE_TAP) begin
            w_state_nxt = DRAIN;
            w_last_iss  = 1'b1;
          end else begin
            w_state_nxt = ACCUM;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ACCUM: begin
        if (w_accept) begin
          w_cnt_nxt = r_cnt + ONE_TAP;
          w_a_iss   = IN_A;
          w_b_iss   = IN_B;
          w_d_iss   = IN_D & {18{PREADD_ON}};
          w_opm_iss = OPM_ACC;
          w_preadd  = PREADD_ON;
          if ((r_cnt + ONE_TAP) == r_taps) begin
            w_state_nxt = DRAIN;
            w_last_iss  = 1'b1;
          end else begin
            w_state_nxt = ACCUM;
          end
        end else begin
          w_state_nxt = ACCUM;
        end
      end
      DRAIN: begin
        if (w_cap) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DRAIN;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // state, counters, handshake flags and issued operands
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= IDLE;
      r_taps     <= {TW{1'b0}};
      r_cnt      <= {TW{1'b0}};
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_ce       <= 1'b0;
      r_dsp_a    <= 18'd0;
      r_dsp_b    <= 18'd0;
      r_dsp_d    <= 18'd0;
      r_opm_iss  <= 8'h00;
      r_last_iss <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_taps     <= w_taps_nxt;
      r_cnt      <= w_cnt_nxt;
      r_in_ready <= (w_state_nxt != DRAIN);
      r_busy     <= (w_state_nxt != IDLE);
      r_ce       <= 1'b1;
      r_dsp_a    <= w_a_iss;
      r_dsp_b    <= w_b_iss;
      r_dsp_d    <= w_d_iss;
      r_opm_iss  <= opm_build(w_opm_iss, w_preadd);
      r_last_iss <= w_last_iss;
    end
  end

  // result capture and consumer handshake
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_res       <= 48'd0;
      r_res_valid <= 1'b0;
      r_p_rdy     <= 1'b0;
    end else begin
      r_p_rdy <= (r_state == DRAIN) & w_p_done & ~w_cap;
      if (w_cap) begin
        r_res       <= DSP_P;
        r_res_valid <= 1'b1;
      end else if (r_res_valid & RES_READY) begin
        r_res_valid <= 1'b0;
      end else begin
        r_res_valid <= r_res_valid;
      end
    end
  end

  dsp_lat_shift #(
    .OPM_SKEW  (OPM_SKEW),
    .TOK_DEPTH (PIPE_LAT + OPM_SKEW)
  ) u_lat (
    .i_clk   (CLK),
    .i_rst_n (RST_N),
    .i_opm   (r_opm_iss),
    .i_last  (r_last_iss),
    .o_opm   (w_opm_dly),
    .o_last  (w_tok_out)
  );

  assign IN_READY   = r_in_ready;
  assign BUSY       = r_busy;
  assign DSP_CE     = r_ce;
  assign DSP_A      = r_dsp_a;
  assign DSP_B      = r_dsp_b;
  assign DSP_D      = r_dsp_d;
  assign DSP_OPMODE = w_opm_dly;
  assign RES        = r_res;
  assign RES_VALID  = r_res_valid;

endmodule
